// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures register operands with EX/MEM and MEM/WB forwarding,
// detects load-use hazards and inserts one bubble, with stall/flush handling.
module id_ex_stage (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               id_valid_i,
  input  logic [4:0]         id_sr1_i,
  input  logic [4:0]         id_sr2_i,
  input  logic [4:0]         id_dr_i,
  input  logic signed [31:0] id_rdata1_i,
  input  logic signed [31:0] id_rdata2_i,
  input  logic signed [31:0] id_imm_i,
  input  logic [7:0]         id_ctrl_i,
  input  logic               exmem_reg_write_i,
  input  logic               memwb_reg_write_i,
  input  logic [4:0]         exmem_dr_i,
  input  logic [4:0]         memwb_dr_i,
  input  logic signed [31:0] exmem_data_i,
  input  logic signed [31:0] memwb_data_i,
  input  logic               ext_stall_i,
  input  logic               flush_i,
  output logic               ex_valid_o,
  output logic signed [31:0] ex_opA_o,
  output logic signed [31:0] ex_opB_o,
  output logic signed [31:0] ex_rs2_data_o,
  output logic [4:0]         ex_dr_o,
  output logic [7:0]         ex_ctrl_o,
  output logic               hazard_stall_o
);

  typedef enum logic [0:0] {RUN = 1'b0, BUBBLE = 1'b1} state_e;

  state_e             state_q, state_d;
  logic               valid_q, valid_d;
  logic signed [31:0] opa_q, opa_d;
  logic signed [31:0] opb_q, opb_d;
  logic signed [31:0] rs2_q, rs2_d;
  logic [4:0]         dr_q, dr_d;
  logic [7:0]         ctrl_q, ctrl_d;

  logic signed [31:0] fwd1_s, fwd2_s;
  logic               uses_sr2_s;
  logic               hazard_s;

  // ctrl layout: [7:4] alu_op, [3] use_imm, [2] reg_write, [1] mem_read, [0] mem_write
  function automatic logic signed [31:0] fwd_sel(
    input logic [4:0]         sr,
    input logic signed [31:0] rdata,
    input logic               exmem_we,
    input logic [4:0]         exmem_dr,
    input logic signed [31:0] exmem_data,
    input logic               memwb_we,
    input logic [4:0]         memwb_dr,
    input logic signed [31:0] memwb_data
  );
    logic signed [31:0] res;
    if (sr == 5'd0) begin
      res = 32'sd0;
    end else if (exmem_we && (exmem_dr == sr)) begin
      res = exmem_data;
    end else if (memwb_we && (memwb_dr == sr)) begin
      res = memwb_data;
    end else begin
      res = rdata;
    end
    return res;
  endfunction

  assign fwd1_s = fwd_sel(id_sr1_i, id_rdata1_i, exmem_reg_write_i, exmem_dr_i, exmem_data_i,
                          memwb_reg_write_i, memwb_dr_i, memwb_data_i);
  assign fwd2_s = fwd_sel(id_sr2_i, id_rdata2_i, exmem_reg_write_i, exmem_dr_i, exmem_data_i,
                          memwb_reg_write_i, memwb_dr_i, memwb_data_i);

  assign uses_sr2_s = ~id_ctrl_i[3] | id_ctrl_i[0];
  assign hazard_s   = id_valid_i & valid_q & ctrl_q[1] & (dr_q != 5'd0) &
                      ((dr_q == id_sr1_i) | ((dr_q == id_sr2_i) & uses_sr2_s));
  assign hazard_stall_o = hazard_s;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (ext_stall_i) begin
          state_d = RUN;
        end else if (flush_i) begin
          state_d = RUN;
        end else if (hazard_s) begin
          state_d = BUBBLE;
        end else begin
          state_d = RUN;
        end
      end
      BUBBLE: begin
        if (ext_stall_i) begin
          state_d = BUBBLE;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Operands are captured even for killed slots; only valid/ctrl mark them dead.
  always_comb begin
    valid_d = valid_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rs2_d   = rs2_q;
    dr_d    = dr_q;
    ctrl_d  = ctrl_q;
    if (ext_stall_i) begin
      valid_d = valid_q;
    end else begin
      opa_d = fwd1_s;
      rs2_d = fwd2_s;
      opb_d = id_ctrl_i[3] ? id_imm_i : fwd2_s;
      dr_d  = id_dr_i;
      if (flush_i || ((state_q == RUN) && hazard_s)) begin
        valid_d = 1'b0;
        ctrl_d  = 8'h00;
      end else begin
        valid_d = id_valid_i;
        ctrl_d  = id_valid_i ? id_ctrl_i : 8'h00;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      opa_q   <= 32'sd0;
      opb_q   <= 32'sd0;
      rs2_q   <= 32'sd0;
      dr_q    <= 5'd0;
      ctrl_q  <= 8'h00;
    end else begin
      valid_q <= valid_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rs2_q   <= rs2_d;
      dr_q    <= dr_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign ex_valid_o    = valid_q;
  assign ex_opA_o      = opa_q;
  assign ex_opB_o      = opb_q;
  assign ex_rs2_data_o = rs2_q;
  assign ex_dr_o       = dr_q;
  assign ex_ctrl_o     = ctrl_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios then randomized traffic
// compared against a cycle-level behavioural model of the pipeline register.
module tb_id_ex_stage;

  logic               clk = 1'b0;
  logic               reset;
  logic               id_valid;
  logic [4:0]         id_sr1, id_sr2, id_dr;
  logic signed [31:0] id_rdata1, id_rdata2, id_imm;
  logic [7:0]         id_ctrl;
  logic               exmem_we, memwb_we;
  logic [4:0]         exmem_dr, memwb_dr;
  logic signed [31:0] exmem_data, memwb_data;
  logic               ext_stall, flush;
  logic               ex_valid;
  logic signed [31:0] ex_opA, ex_opB, ex_rs2;
  logic [4:0]         ex_dr;
  logic [7:0]         ex_ctrl;
  logic               hazard;

  int checks = 0;
  int errors = 0;

  // Model of the EX-side register contents
  logic        m_valid;
  logic [31:0] m_opa, m_opb, m_rs2;
  logic [4:0]  m_dr;
  logic [7:0]  m_ctrl;

  localparam logic [7:0] LOAD = 8'h2E;  // alu 2, use_imm, reg_write, mem_read
  localparam logic [7:0] ALUR = 8'h14;  // alu 1, reg_write, register operands
  localparam logic [7:0] ALUI = 8'h3C;  // alu 3, use_imm, reg_write
  localparam logic [7:0] STOR = 8'h49;  // alu 4, use_imm, mem_write

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk_i(clk), .reset_i(reset), .id_valid_i(id_valid),
    .id_sr1_i(id_sr1), .id_sr2_i(id_sr2), .id_dr_i(id_dr),
    .id_rdata1_i(id_rdata1), .id_rdata2_i(id_rdata2), .id_imm_i(id_imm), .id_ctrl_i(id_ctrl),
    .exmem_reg_write_i(exmem_we), .memwb_reg_write_i(memwb_we),
    .exmem_dr_i(exmem_dr), .memwb_dr_i(memwb_dr),
    .exmem_data_i(exmem_data), .memwb_data_i(memwb_data),
    .ext_stall_i(ext_stall), .flush_i(flush),
    .ex_valid_o(ex_valid), .ex_opA_o(ex_opA), .ex_opB_o(ex_opB), .ex_rs2_data_o(ex_rs2),
    .ex_dr_o(ex_dr), .ex_ctrl_o(ex_ctrl), .hazard_stall_o(hazard)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value the decode stage should see for a source register this cycle
  function automatic logic [31:0] ref_operand(input logic [4:0] sr, input logic [31:0] rdata);
    if (sr == 5'd0) return 32'd0;
    if (exmem_we && exmem_dr == sr) return exmem_data;
    if (memwb_we && memwb_dr == sr) return memwb_data;
    return rdata;
  endfunction

  function automatic logic ref_hazard();
    logic needs_sr2;
    needs_sr2 = !id_ctrl[3] || id_ctrl[0];
    return id_valid && m_valid && m_ctrl[1] && (m_dr != 5'd0) &&
           ((m_dr == id_sr1) || (needs_sr2 && m_dr == id_sr2));
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_opa = 32'd0; m_opb = 32'd0; m_rs2 = 32'd0; m_dr = 5'd0; m_ctrl = 8'h00;
  endtask

  task automatic set_idle();
    id_valid = 1'b0; id_sr1 = 5'd0; id_sr2 = 5'd0; id_dr = 5'd0;
    id_rdata1 = 32'sd0; id_rdata2 = 32'sd0; id_imm = 32'sd0; id_ctrl = 8'h00;
    exmem_we = 1'b0; memwb_we = 1'b0; exmem_dr = 5'd0; memwb_dr = 5'd0;
    exmem_data = 32'sd0; memwb_data = 32'sd0; ext_stall = 1'b0; flush = 1'b0;
  endtask

  task automatic set_instr(input logic [7:0] c, input logic [4:0] s1, input logic [4:0] s2,
                           input logic [4:0] d);
    id_valid = 1'b1; id_ctrl = c; id_sr1 = s1; id_sr2 = s2; id_dr = d;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
    chk({tag, "_opA"}, ex_opA, 32'd0);
    chk({tag, "_opB"}, ex_opB, 32'd0);
    chk({tag, "_rs2"}, ex_rs2, 32'd0);
    chk({tag, "_dr"}, {27'd0, ex_dr}, 32'd0);
    chk({tag, "_ctrl"}, {24'd0, ex_ctrl}, 32'd0);
    chk({tag, "_hazard"}, {31'd0, hazard}, 32'd0);
  endtask

  // One cycle: inputs already driven after a negedge; checks hazard, clocks, checks EX
  task automatic step();
    logic        haz, n_valid;
    logic [31:0] n_opa, n_opb, n_rs2;
    logic [4:0]  n_dr;
    logic [7:0]  n_ctrl;
    #1;
    haz = ref_hazard();
    chk("hazard_stall", {31'd0, hazard}, {31'd0, haz});
    n_valid = m_valid; n_opa = m_opa; n_opb = m_opb; n_rs2 = m_rs2; n_dr = m_dr; n_ctrl = m_ctrl;
    if (!ext_stall) begin
      n_opa = ref_operand(id_sr1, id_rdata1);
      n_rs2 = ref_operand(id_sr2, id_rdata2);
      n_opb = id_ctrl[3] ? id_imm : n_rs2;
      n_dr  = id_dr;
      n_valid = id_valid && !flush && !haz;
      n_ctrl  = n_valid ? id_ctrl : 8'h00;
    end
    @(posedge clk);
    m_valid = n_valid; m_opa = n_opa; m_opb = n_opb; m_rs2 = n_rs2; m_dr = n_dr; m_ctrl = n_ctrl;
    #1;
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
    chk("ex_ctrl", {24'd0, ex_ctrl}, {24'd0, m_ctrl});
    if (m_valid) begin
      chk("ex_opA", ex_opA, m_opa);
      chk("ex_opB", ex_opB, m_opb);
      chk("ex_rs2", ex_rs2, m_rs2);
      chk("ex_dr", {27'd0, ex_dr}, {27'd0, m_dr});
    end
    @(negedge clk);
  endtask

  initial begin
    set_idle();
    model_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("por");

    // EX/MEM beats MEM/WB beats register file
    set_instr(ALUR, 5'd5, 5'd1, 5'd9);
    id_rdata1 = 32'sd10; exmem_we = 1'b1; exmem_dr = 5'd5; exmem_data = 32'sd77;
    memwb_we = 1'b1; memwb_dr = 5'd5; memwb_data = 32'sd33;
    step();
    chk("exmem_fwd_opA", ex_opA, 32'd77);

    // MEM/WB forward on sr2, r0 always zero
    set_idle();
    set_instr(ALUR, 5'd0, 5'd3, 5'd4);
    id_rdata1 = 32'sd99; id_rdata2 = 32'sd8; exmem_we = 1'b1; exmem_dr = 5'd0; exmem_data = 32'sd55;
    memwb_we = 1'b1; memwb_dr = 5'd3; memwb_data = -32'sd4;
    step();
    chk("memwb_fwd_opB", ex_opB, 32'hFFFF_FFFC);
    chk("r0_opA", ex_opA, 32'd0);

    // Load-use: one bubble, then recapture forwarded from MEM/WB
    set_idle();
    set_instr(LOAD, 5'd2, 5'd0, 5'd7);
    step();
    set_idle();
    set_instr(ALUR, 5'd7, 5'd1, 5'd8);
    id_rdata1 = 32'sd1; id_rdata2 = 32'sd2;
    #1;
    chk("loaduse_hazard", {31'd0, hazard}, 32'd1);
    step();
    chk("loaduse_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("loaduse_bubble_ctrl", {24'd0, ex_ctrl}, 32'd0);
    memwb_we = 1'b1; memwb_dr = 5'd7; memwb_data = 32'sd123;
    step();
    chk("loaduse_recapture_valid", {31'd0, ex_valid}, 32'd1);
    chk("loaduse_recapture_opA", ex_opA, 32'd123);

    // Immediate op does not depend on sr2; store does
    set_idle();
    set_instr(LOAD, 5'd1, 5'd0, 5'd6);
    step();
    set_idle();
    set_instr(ALUI, 5'd1, 5'd6, 5'd2);
    id_imm = -32'sd16;
    step();
    chk("imm_no_hazard_valid", {31'd0, ex_valid}, 32'd1);
    chk("imm_opB", ex_opB, 32'hFFFF_FFF0);
    set_idle();
    set_instr(LOAD, 5'd1, 5'd0, 5'd6);
    step();
    set_idle();
    set_instr(STOR, 5'd1, 5'd6, 5'd0);
    #1;
    chk("store_sr2_hazard", {31'd0, hazard}, 32'd1);
    step();

    // ext_stall for three cycles freezes everything
    set_idle();
    set_instr(ALUR, 5'd3, 5'd4, 5'd11);
    id_rdata1 = 32'sd300; id_rdata2 = 32'sd400;
    step();
    set_instr(ALUI, 5'd1, 5'd2, 5'd12);
    id_rdata1 = 32'sd1; id_imm = 32'sd5;
    ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_opA", ex_opA, 32'd300);
      chk("stall_dr", {27'd0, ex_dr}, 32'd11);
    end
    ext_stall = 1'b0;
    step();

    // flush together with a load-use hazard: flush wins, next cycle captures normally
    set_idle();
    set_instr(LOAD, 5'd0, 5'd0, 5'd9);
    step();
    set_idle();
    set_instr(ALUR, 5'd9, 5'd0, 5'd3);
    flush = 1'b1;
    #1;
    chk("flush_hazard_reported", {31'd0, hazard}, 32'd1);
    step();
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    flush = 1'b0;
    id_rdata1 = 32'sd42;
    step();
    chk("after_flush_valid", {31'd0, ex_valid}, 32'd1);
    chk("after_flush_opA", ex_opA, 32'd42);

    // Asynchronous reset mid-cycle while a hazard is pending
    set_idle();
    set_instr(LOAD, 5'd0, 5'd0, 5'd7);
    step();
    set_instr(ALUR, 5'd7, 5'd0, 5'd1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    reset = 1'b0;
    step();

    // Randomized traffic over a small register window to provoke forwarding/hazards
    for (int n = 0; n < 400; n++) begin
      id_valid   = ($urandom_range(0, 9) < 8);
      id_sr1     = 5'($urandom_range(0, 7));
      id_sr2     = 5'($urandom_range(0, 7));
      id_dr      = 5'($urandom_range(0, 7));
      id_rdata1  = $urandom;
      id_rdata2  = $urandom;
      id_imm     = $urandom;
      case ($urandom_range(0, 4))
        0: id_ctrl = LOAD;
        1: id_ctrl = ALUR;
        2: id_ctrl = ALUI;
        3: id_ctrl = STOR;
        default: id_ctrl = 8'($urandom);
      endcase
      exmem_we   = $urandom_range(0, 1);
      memwb_we   = $urandom_range(0, 1);
      exmem_dr   = 5'($urandom_range(0, 7));
      memwb_dr   = 5'($urandom_range(0, 7));
      exmem_data = $urandom;
      memwb_data = $urandom;
      ext_stall  = ($urandom_range(0, 9) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage sitting directly downstream of the register bank. It captures the two register operands read at the negative edge, resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages, and detects load-use hazards. It registers operands, immediate and control fields for the ALU stage, with stall/flush control and a valid bit.

## Interface
- (no parameters; data width fixed at 32, register index width fixed at 5)
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all registered state
- id_valid  in  1  decode stage holds a real instruction
- id_sr1, id_sr2, id_dr  in  5 each  source/destination indices (same as sent to register bank)
- id_rdata1, id_rdata2  in  32 signed  register bank read data (stable by posedge)
- id_imm  in  32 signed  sign-extended immediate
- id_ctrl  in  8  {alu_op[3:0], use_imm, reg_write, mem_read, mem_write}
- exmem_reg_write, memwb_reg_write  in  1 each  producer will write its dr
- exmem_dr, memwb_dr  in  5 each  producer destinations
- exmem_data, memwb_data  in  32 signed  producer results
- ext_stall  in  1  downstream stall; hold all outputs
- flush  in  1  branch redirect; kill instruction entering EX
- ex_valid  out  1  EX holds a real instruction
- ex_opA, ex_opB  out  32 signed  forwarded operands (opB = imm when use_imm)
- ex_rs2_data  out  32 signed  forwarded second register (store data)
- ex_dr  out  5 ; ex_ctrl  out  8
- hazard_stall  out  1  combinational; freeze PC and IF/ID this cycle

## Operation
- Forwarding per source (sr1, sr2), priority order: EX/MEM match (exmem_reg_write, exmem_dr==sr, sr!=0) -> exmem_data; else MEM/WB match -> memwb_data; else id_rdata. Index 0 never forwarded; operand of r0 is always 0 regardless of id_rdata.
- MEM/WB forwarding is mandatory: the register bank writes at posedge after its negedge read, so same-cycle writeback is not visible in id_rdata.
- Load-use: hazard_stall = id_valid & ex_valid & ex_ctrl.mem_read & ex_dr!=0 & (ex_dr==id_sr1 | (ex_dr==id_sr2 & id uses sr2)). id uses sr2 when use_imm=0 or mem_write=1.
- State machine, 2 states: RUN, BUBBLE. RUN: on hazard_stall load a bubble (ex_valid=0, ex_ctrl=0) and go to BUBBLE. BUBBLE: hazard_stall deasserted by construction (EX now invalid); capture decode normally, return to RUN.
- Posedge update priority: reset > ext_stall (hold everything, state unchanged) > flush (ex_valid=0, ex_ctrl=0, state->RUN) > hazard_stall (bubble) > normal capture (ex_valid=id_valid; ctrl zeroed when id_valid=0).
- flush and hazard_stall together: flush wins; hazard_stall still reported combinationally.
- Invalid slots carry ex_ctrl=0 so no downstream write/memory side effects.

## Timing
- Reset values: ex_valid=0, ex_opA=0, ex_opB=0, ex_rs2_data=0, ex_dr=0, ex_ctrl=0, state=RUN; hazard_stall=0 while ex_valid=0.
- Latency: one cycle, decode inputs at posedge N appear on ex_* after posedge N.
- Forwarding mux and hazard_stall are combinational from current inputs/registered EX state; no registered forwarding.
- Load-use costs exactly one bubble; the held instruction is recaptured the next cycle and forwarded from MEM/WB or EX/MEM.
- Reset asserted mid-stall or mid-bubble: immediate clear to reset values, state RUN.

## Test plan
- Reset: assert reset asynchronously between edges with ex_valid=1 -> all outputs 0 immediately, hazard_stall=0.
- EX/MEM forward: id_sr1=5, id_rdata1=10, exmem_reg_write=1, exmem_dr=5, exmem_data=77, memwb_dr=5, memwb_data=33 -> ex_opA=77 after posedge.
- MEM/WB forward and r0: id_sr2=3, use_imm=0, memwb_dr=3, memwb_data=-4 -> ex_opB=-4; id_sr1=0, id_rdata1=99, exmem_dr=0 -> ex_opA=0.
- Load-use: EX holds load to r7; decode reads sr1=7 -> hazard_stall=1, next cycle ex_valid=0, ex_ctrl=0; following cycle instruction enters with opA from memwb_data.
- Immediate: use_imm=1, id_imm=-16, mem_write=0, EX load to id_sr2 -> no hazard_stall, ex_opB=-16.
- Stall/flush: ext_stall=1 for 3 cycles -> outputs frozen; flush=1 with hazard_stall=1 -> ex_valid=0, state RUN, next cycle normal capture.
